mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 23 ++
 rtl/mul_div_unit.sv | 134 +++++++++++++
 tb/tb_mul_div_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared CPU control encodings for the HI/LO multiply-divide unit.
// Op codes and default latencies live here so decode and the unit agree.
package mul_div_unit_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: operands are latched at issue and
// the result lands in HI/LO on the same edge that busy drops.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic              state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       a_p0;
    logic [31:0]       b_p0;
    logic [2:0]        op_p0;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               res_we;
    logic        [31:0] res_hi;
    logic        [31:0] res_lo;
    logic               done;

    // Returns {remainder, quotient}; the one overflowing case is pinned explicitly.
    function automatic logic [63:0] sdiv(input logic signed [31:0] n, input logic signed [31:0] d);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (d == 32'sd0) begin
            q = 32'sd0;
            r = 32'sd0;
        end else if (n == 32'sh8000_0000 && d == -32'sd1) begin
            q = n;
            r = 32'sd0;
        end else begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] udiv(input logic [31:0] n, input logic [31:0] d);
        if (d == 32'd0) begin
            return 64'd0;
        end
        return {n % d, n / d};
    endfunction

    assign busy   = (state == RUN);
    assign done   = (state == RUN) && (cnt <= CNT_W'(1));
    assign prod_s = $signed({{32{a_p0[31]}}, a_p0}) * $signed({{32{b_p0[31]}}, b_p0});
    assign prod_u = {32'd0, a_p0} * {32'd0, b_p0};

    always_comb begin
        res_we = 1'b0;
        res_hi = HI;
        res_lo = LO;
        case (op_p0)
            OP_MULT: begin
                res_we           = 1'b1;
                {res_hi, res_lo} = prod_s;
            end
            OP_MULTU: begin
                res_we           = 1'b1;
                {res_hi, res_lo} = prod_u;
            end
            OP_DIV: begin
                res_we           = (b_p0 != 32'd0);
                {res_hi, res_lo} = sdiv(a_p0, b_p0);
            end
            OP_DIVU: begin
                res_we           = (b_p0 != 32'd0);
                {res_hi, res_lo} = udiv(a_p0, b_p0);
            end
            default: ;
        endcase
    end

    // Issue stage: operands track the inputs while idle and freeze on entry to RUN.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            a_p0  <= A;
            b_p0  <= B;
            op_p0 <= op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            HI    <= '0;
            LO    <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                if (is_mul(op)) begin
                    cnt   <= CNT_W'(MULT_CYCLES);
                    state <= RUN;
                end else if (is_div(op)) begin
                    cnt   <= CNT_W'(DIV_CYCLES);
                    state <= RUN;
                end else if (op == OP_MTHI) begin
                    HI <= A;
                end else if (op == OP_MTLO) begin
                    LO <= A;
                end
            end
        end else if (done) begin
            state <= IDLE;
            cnt   <= '0;
            if (res_we) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: stimulus pushes expected HI/LO and busy
// length into a scoreboard; a monitor pops and checks on each completion.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb_hi[$];
    logic [31:0] sb_lo[$];
    int          sb_cyc[$];
    string       sb_name[$];

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic expect_res(input string nm, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
        sb_name.push_back(nm);
        sb_hi.push_back(hi);
        sb_lo.push_back(lo);
        sb_cyc.push_back(cyc);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    // Monitor: a falling busy marks a completion unless reset caused it.
    initial begin
        int run = 0;
        forever begin
            @(negedge clk);
            if (busy) begin
                run++;
            end else if (run != 0) begin
                if (reset !== 1'b1) begin
                    if (sb_name.size() == 0) begin
                        chk("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        string nm;
                        nm = sb_name.pop_front();
                        chk({nm, "_hi"}, HI, sb_hi.pop_front());
                        chk({nm, "_lo"}, LO, sb_lo.pop_front());
                        chk({nm, "_busy_cycles"}, run, sb_cyc.pop_front());
                    end
                end
                run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        #1 reset = 1'b0;

        expect_res("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        issue(3'd0, 32'hFFFF_FFFF, 32'd2);
        wait_idle("mult_neg");

        expect_res("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_idle("multu");

        expect_res("mult_2p32", 32'h0000_0001, 32'h0000_0000, 5);
        issue(3'd0, 32'h0001_0000, 32'h0001_0000);
        wait_idle("mult_2p32");

        expect_res("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div_m7_2");

        expect_res("divu_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd3, 32'd5, 32'd0);
        wait_idle("divu_by0");

        expect_res("div_ovf", 32'h0000_0000, 32'h8000_0000, 10);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf");

        issue(3'd4, 32'h1234_5678, 32'd0);
        @(negedge clk);
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_lo", LO, 32'h8000_0000);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("mthi_busy_next", {31'd0, busy}, 32'd0);

        expect_res("mult_3x4", 32'h0000_0000, 32'h0000_000C, 5);
        issue(3'd0, 32'd3, 32'd4);
        start = 1'b1;
        op    = 3'd5;
        A     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("mtlo_in_run_lo", LO, 32'h8000_0000);
        wait_idle("mult_3x4");

        issue(3'd6, 32'h5555_5555, 32'd1);
        @(negedge clk);
        chk("op6_hi", HI, 32'h0000_0000);
        chk("op6_lo", LO, 32'h0000_000C);
        chk("op6_busy", {31'd0, busy}, 32'd0);
        issue(3'd7, 32'h5555_5555, 32'd1);
        @(negedge clk);
        chk("op7_lo", LO, 32'h0000_000C);
        chk("op7_busy", {31'd0, busy}, 32'd0);

        expect_res("mult_5x6", 32'h0000_0000, 32'h0000_001E, 5);
        issue(3'd0, 32'd5, 32'd6);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 3'd0;
        A     = 32'd7;
        B     = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("start_at_done_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("start_at_done_busy_next", {31'd0, busy}, 32'd0);
        chk("start_at_done_lo", LO, 32'h0000_001E);

        expect_res("div_churn", 32'hFFFF_FFFE, 32'hFFFF_FFF2, 10);
        issue(3'd2, 32'hFFFF_FF9C, 32'd7);
        A = $urandom;
        B = $urandom;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            A = $urandom;
            B = $urandom;
        end
        wait_idle("div_churn");

        expect_res("divu_100_7", 32'h0000_0002, 32'h0000_000E, 10);
        issue(3'd3, 32'd100, 32'd7);
        wait_idle("divu_100_7");

        expect_res("divu_big", 32'h0000_000F, 32'h0FFF_FFFF, 10);
        issue(3'd3, 32'hFFFF_FFFF, 32'h0000_0010);
        wait_idle("divu_big");

        issue(3'd0, 32'd3, 32'd5);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_run_busy", {31'd0, busy}, 32'd0);
        chk("rst_run_hi", HI, 32'd0);
        chk("rst_run_lo", LO, 32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_hold_hi", HI, 32'd0);
            chk("rst_hold_lo", LO, 32'd0);
            chk("rst_hold_busy", {31'd0, busy}, 32'd0);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb_name.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
